// File: rtl/instr_mem_loader.sv
// Instruction memory loader: accepts 32-bit words on a valid/ready stream and
// writes each one as four little-endian byte writes from a programmable base.
module instr_mem_loader #(
    parameter int dataWidth = 64,
    parameter int memWidth  = 64,
    parameter int cntWidth  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [dataWidth-1:0] baseAddr,
    input  logic                 inValid,
    input  logic [31:0]          inWord,
    input  logic                 inLast,
    output logic                 inReady,
    output logic                 memWe,
    output logic [dataWidth-1:0] memAddr,
    output logic [7:0]           memData,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [cntWidth-1:0]  wordsLoaded
);

    localparam logic [dataWidth-1:0] memLimit = dataWidth'(memWidth);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t               state, state_next;
    logic [dataWidth-1:0] ptr;
    logic [dataWidth-1:0] addr_hold;
    logic [31:0]          word;
    logic                 last;
    logic [1:0]           byte_idx;
    logic [7:0]           data_hold;
    logic [7:0]           cur_byte;
    logic                 in_range;

    assign in_range = ptr < memLimit;
    assign cur_byte = word[{byte_idx, 3'b000} +: 8];

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = ACCEPT;
            ACCEPT:  if (inValid)  state_next = WRITE;
            WRITE:   if (byte_idx == 2'd3) state_next = last ? DONE : ACCEPT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outside WRITE the bus shows the last address/byte that was presented.
    assign inReady = (state == ACCEPT);
    assign memWe   = (state == WRITE) && in_range;
    assign memAddr = (state == WRITE) ? ptr      : addr_hold;
    assign memData = (state == WRITE) ? cur_byte : data_hold;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            addr_hold   <= '0;
            word        <= '0;
            last        <= 1'b0;
            byte_idx    <= 2'd0;
            data_hold   <= '0;
            err         <= 1'b0;
            wordsLoaded <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr         <= baseAddr;
                        err         <= 1'b0;
                        wordsLoaded <= '0;
                    end
                end
                ACCEPT: begin
                    if (inValid) begin
                        word     <= inWord;
                        last     <= inLast;
                        byte_idx <= 2'd0;
                        if (wordsLoaded != {cntWidth{1'b1}})
                            wordsLoaded <= wordsLoaded + 1'b1;
                    end
                end
                WRITE: begin
                    // Out-of-range bytes are dropped but the pointer still advances.
                    addr_hold <= ptr;
                    data_hold <= cur_byte;
                    ptr       <= ptr + 1'b1;
                    byte_idx  <= byte_idx + 2'd1;
                    if (!in_range) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart of the byte-addressed instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and serialises each word into four byte writes, little-endian, at consecutive byte addresses from a programmable base.
- Sits between a boot/test program source and the instruction memory byte write port, and fills memory before the fetch side reads it.

Parameters:
- dataWidth, 64, width of byte addresses (matches the PC width).
- memWidth, 64, instruction memory depth in bytes; legal addresses are 0..memWidth-1.
- cntWidth, 16, width of the loaded-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load session; sampled only in IDLE.
- baseAddr  input  dataWidth  first byte address of the session; captured on an accepted start.
- inValid  input  1  inWord/inLast are valid.
- inWord  input  32  instruction word to store.
- inLast  input  1  the current word is the final word of the session.
- inReady  output  1  loader can accept a word this cycle.
- memWe  output  1  byte write enable to instruction memory.
- memAddr  output  dataWidth  byte write address.
- memData  output  8  byte write data.
- busy  output  1  session in progress (state is not IDLE).
- done  output  1  one-cycle pulse when a session completes.
- err  output  1  sticky flag: at least one byte address was at or above memWidth this session.
- wordsLoaded  output  cntWidth  words accepted in the current or most recent session.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; inReady, memWe, busy, done, err = 0; memAddr, memData, wordsLoaded = 0. Reset mid-session aborts it immediately. Bytes already written stay written. No further writes occur.
- State IDLE:
  - inReady=0.
  - start=1 captures ptr<=baseAddr, clears err and wordsLoaded, and moves to ACCEPT.
  - start is ignored in every other state.
- State ACCEPT:
  - inReady=1.
  - On inValid&inReady: latch word<=inWord and last<=inLast, increment wordsLoaded, set byteIdx=0, and move to WRITE.
  - With inValid=0, stay in ACCEPT indefinitely.
- State WRITE (exactly 4 cycles, byteIdx 0..3):
  - inReady=0.
  - memAddr=ptr.
  - memData=word[8*byteIdx+7 : 8*byteIdx], so the LSB goes first (byte0 to ptr, byte3 to ptr+3).
  - memWe=1 when ptr<memWidth. Otherwise memWe=0 and err<=1; the write is dropped but the address still advances.
  - ptr increments by 1 each cycle. ptr arithmetic is dataWidth wide and wraps modulo 2^dataWidth; there is no wrap to 0 at memWidth.
  - After byteIdx=3: go to DONE if last=1, else to ACCEPT.
- State DONE: done=1 for exactly one cycle, then IDLE. err and wordsLoaded hold their values until the next accepted start.
- Throughput: one word per 5 cycles minimum (1 accept plus 4 write cycles).
- Latency: the first byte write occurs the cycle after the accept.
- Outside WRITE: memWe=0, and memAddr/memData hold their last values.
- inWord and inLast are sampled only on the accept cycle; later changes have no effect.
- wordsLoaded saturates at 2^cntWidth-1.
- busy=1 in ACCEPT, WRITE and DONE.

Test Plan:
- Single word: reset, start with baseAddr=0, then inWord=32'h00000033 with inLast=1. Required: four writes (0,33),(1,00),(2,00),(3,00) on consecutive cycles; done pulses one cycle after the last write; wordsLoaded=1; err=0.
- Four-word burst with inValid held high: words 33, 03, 23, 63 (LSB), base=0, inLast on the fourth. Required: bytes 0, 4, 8, 12 = 33, 03, 23, 63; 16 writes; each accept 5 cycles apart; done once.
- Overflow: memWidth=64, base=62, one word 32'hDDCCBBAA with last=1. Required: writes (62,AA),(63,BB); addresses 64 and 65 have memWe=0; err=1 after done.
- Backpressure: hold inValid=0 in ACCEPT for 10 cycles. Required: inReady=1 throughout, memWe=0, and a word presented afterwards is written normally.
- Reset mid-WRITE (after byte 1 of a word at base 8): rst_n=0 for one edge. Required: next cycle state is IDLE, all outputs 0, no write to addresses 10 or 11.
- start asserted during ACCEPT or WRITE: ignored. ptr, wordsLoaded and err are unchanged, and the session completes normally.
